clk_div_prog: RTL and testbench

Programmable 50%-duty clock divider. It generates `clk_out` at the input clock frequency divided by N, for any even or odd N from 2 to 2^WIDTH−1. N can be changed at run time, and a change takes effect only at a period boundary, so no output period is ever truncated or glitched. It is the parametrised successor to the fixed even divider and feeds low-speed peripheral clocks and sample-rate strobes from the 25 MHz system clock.

---
 rtl/clk_div_prog.sv | 123 ++++++++++++
 tb/tb_clk_div_prog.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable 50%-duty clock divider for any ratio 2..2^WIDTH-1.
// Ratio updates and run/stop requests take effect only at output period boundaries.
module clk_div_prog #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned DEFAULT_DIV = 40
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] div,
   input  logic             div_load,
   output logic             clk_out,
   output logic             tick,
   output logic [WIDTH-1:0] div_active,
   output logic             pending,
   output logic             err
);

   localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);

   // Refuse to elaborate with a reset ratio the counter cannot produce.
   if ((WIDTH < 32'd2) || (DEFAULT_DIV < 32'd2) ||
       (64'(DEFAULT_DIV) > ((64'd1 << WIDTH) - 64'd1))) begin : g_bad_param
      $error("clk_div_prog: DEFAULT_DIV must lie in [2, 2^WIDTH-1]");
   end

   typedef enum logic {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] div_active_q, div_active_d;
   logic [WIDTH-1:0] div_pend_q, div_pend_d;
   logic             pending_q, pending_d;
   logic             pos_q, pos_d;
   logic             neg_q;
   logic             tick_q, tick_d;
   logic             err_q, err_d;
   logic             boundary_c;
   logic             load_ok_c;
   logic [WIDTH-1:0] half_c;

   // Next-state: period boundary handling, counter advance, load capture.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      div_active_d = div_active_q;
      div_pend_d   = div_pend_q;
      pending_d    = pending_q;
      err_d        = 1'b0;
      pos_d        = 1'b0;
      tick_d       = 1'b0;
      boundary_c   = (state_q == ST_STOP) || (cnt_q == (div_active_q - WIDTH'(1)));
      load_ok_c    = div_load && (div >= DIV_MIN);
      half_c       = '0;

      if (boundary_c) begin
         if (pending_q) begin
            div_active_d = div_pend_q;
            pending_d    = 1'b0;
         end
         state_d = en ? ST_RUN : ST_STOP;
         if (en) begin
            cnt_d = '0;
         end
      end else begin
         cnt_d = cnt_q + WIDTH'(1);
      end

      // A load landing on a boundary cycle is held for the next boundary.
      if (load_ok_c) begin
         div_pend_d = div;
         pending_d  = 1'b1;
      end
      err_d = div_load && !load_ok_c;

      // floor(N/2) posedge-high cycles; odd ratios get the extra half from neg_q.
      half_c = div_active_d >> 1;
      pos_d  = (state_d == ST_RUN) && (cnt_d < half_c);
      tick_d = (state_d == ST_RUN) && (cnt_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_STOP;
         cnt_q        <= '0;
         div_active_q <= DIV_RST;
         div_pend_q   <= DIV_RST;
         pending_q    <= 1'b0;
         pos_q        <= 1'b0;
         tick_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         div_active_q <= div_active_d;
         div_pend_q   <= div_pend_d;
         pending_q    <= pending_d;
         pos_q        <= pos_d;
         tick_q       <= tick_d;
         err_q        <= err_d;
      end
   end

   // Half-cycle stretch for odd ratios; forced low for even ratios.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_q <= 1'b0;
      end else begin
         neg_q <= pos_q & div_active_q[0];
      end
   end

   assign clk_out    = pos_q | neg_q;
   assign tick       = tick_q;
   assign err        = err_q;
   assign pending    = pending_q;
   assign div_active = div_active_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomised self-checking bench for clk_div_prog against a period-level model.
module tb_clk_div_prog;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] div;
   logic       div_load;
   logic       clk_out;
   logic       tick;
   logic [7:0] div_active;
   logic       pending;
   logic       err;

   int total = 0;
   int bad   = 0;

   clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(40)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .div        (div),
      .div_load   (div_load),
      .clk_out    (clk_out),
      .tick       (tick),
      .div_active (div_active),
      .pending    (pending),
      .err        (err)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   // Model: position m_k (input cycles) inside the current output period of m_n cycles.
   bit m_run, m_pv, m_err;
   int m_k, m_n, m_pn;

   function automatic void model_reset();
      m_run = 1'b0; m_pv = 1'b0; m_err = 1'b0;
      m_k = 0; m_n = 40; m_pn = 40;
   endfunction

   function automatic void model_edge(input bit e, input bit ld, input int d);
      bit period_over;
      period_over = !m_run || (m_k + 1 == m_n);
      m_err = ld && (d < 2);
      if (period_over) begin
         if (m_pv) begin
            m_n  = m_pn;
            m_pv = 1'b0;
         end
         m_run = e;
         m_k   = 0;
      end else begin
         m_k = m_k + 1;
      end
      if (ld && d >= 2) begin
         m_pn = d;
         m_pv = 1'b1;
      end
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   // The output is high for the first N half-cycles of every running period.
   task automatic compare_all(input int half);
      bit exp_clk;
      exp_clk = m_run && ((2 * m_k + half) < m_n);
      check(half ? "clk_out_lo_half" : "clk_out_hi_half", 32'(clk_out), 32'(exp_clk));
      check("tick", 32'(tick), 32'(m_run && m_k == 0));
      check("div_active", 32'(div_active), 32'(m_n));
      check("pending", 32'(pending), 32'(m_pv));
      check("err", 32'(err), 32'(m_err));
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (rst_n === 1'b1) model_edge(en, div_load, int'(div));
         #1;
         compare_all(0);
         @(negedge clk);
         #1;
         compare_all(1);
      end
   end

   // Waveform measurements used to pin the model with literal timings.
   time t_rise = 0, hi_t = 0, per_t = 0;
   always @(posedge clk_out) begin
      per_t  = $time - t_rise;
      t_rise = $time;
   end
   always @(negedge clk_out) hi_t = $time - t_rise;

   task automatic cyc(input bit e, input bit ld, input int d);
      en       = e;
      div_load = ld;
      div      = 8'(d);
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0);
   endtask

   task automatic wait_nk(input int n, input int k);
      int g;
      g = 0;
      while (!(m_run && m_n == n && m_k == k) && g < 400) begin
         cyc(1'b1, 1'b0, 0);
         g++;
      end
      if (g >= 400) begin
         total++;
         bad++;
         $display("FAIL wait_nk n=%0d k=%0d: not reached within %0d cycles", n, k, g);
      end
   endtask

   initial begin
      en = 1'b0; div_load = 1'b0; div = '0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_clk_out", 32'(clk_out), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      check("rst_div_active", 32'(div_active), 32'd40);
      rst_n = 1'b1;
      cyc(1'b0, 1'b0, 0);
      cyc(1'b0, 1'b0, 0);
      check("stopped_clk_out", 32'(clk_out), 32'd0);

      // Start: first enabled posedge raises clk_out and tick.
      cyc(1'b1, 1'b0, 0);
      check("start_clk_out", 32'(clk_out), 32'd1);
      check("start_tick", 32'(tick), 32'd1);
      run(85);
      check("n40_period_ns", 32'(per_t), 32'd1600);
      check("n40_high_ns", 32'(hi_t), 32'd800);

      // Odd ratio 5 after the current 40-cycle period.
      cyc(1'b1, 1'b1, 5);
      check("load5_pending", 32'(pending), 32'd1);
      check("load5_still_40", 32'(div_active), 32'd40);
      wait_nk(5, 0);
      run(12);
      check("n5_period_ns", 32'(per_t), 32'd200);
      check("n5_high_ns", 32'(hi_t), 32'd100);

      // Mid-period load of 6 must not shorten the running 40-cycle period.
      cyc(1'b1, 1'b1, 40);
      wait_nk(40, 10);
      cyc(1'b1, 1'b1, 6);
      wait_nk(6, 0);
      check("n40_full_before_6", 32'(per_t), 32'd1600);
      run(13);
      check("n6_period_ns", 32'(per_t), 32'd240);
      check("n6_high_ns", 32'(hi_t), 32'd120);

      // Invalid ratios are rejected without disturbing a pending 9.
      cyc(1'b1, 1'b1, 9);
      cyc(1'b1, 1'b1, 1);
      check("err_on_1", 32'(err), 32'd1);
      check("pend_kept_1", 32'(pending), 32'd1);
      cyc(1'b1, 1'b1, 0);
      check("err_on_0", 32'(err), 32'd1);
      cyc(1'b1, 1'b0, 0);
      check("err_clears", 32'(err), 32'd0);
      wait_nk(9, 0);
      check("n9_applied", 32'(div_active), 32'd9);

      // Stop request mid-period completes the 8-cycle period first.
      cyc(1'b1, 1'b1, 8);
      wait_nk(8, 5);
      for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 0);
      check("stop_clk_out", 32'(clk_out), 32'd0);
      check("stop_last_high_ns", 32'(hi_t), 32'd160);
      cyc(1'b1, 1'b0, 0);
      check("restart_clk_out", 32'(clk_out), 32'd1);
      check("restart_tick", 32'(tick), 32'd1);

      // Asynchronous reset in the high phase with a ratio pending.
      cyc(1'b1, 1'b1, 12);
      check("pre_rst_pending", 32'(pending), 32'd1);
      check("pre_rst_clk_out", 32'(clk_out), 32'd1);
      #5;
      en    = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_rst_clk_out", 32'(clk_out), 32'd0);
      check("async_rst_pending", 32'(pending), 32'd0);
      check("async_rst_div_active", 32'(div_active), 32'd40);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b1, 1'b0, 0);
      check("post_rst_clk_out", 32'(clk_out), 32'd1);
      check("post_rst_div_active", 32'(div_active), 32'd40);

      // Random run/stop and load traffic checked cycle by cycle.
      for (int i = 0; i < 2000; i++) begin
         bit e, ld;
         int d;
         e  = ($urandom_range(0, 24) != 0);
         ld = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0:       d = int'($urandom_range(0, 1));
            1:       d = int'($urandom_range(2, 9));
            2:       d = int'($urandom_range(2, 255));
            default: d = int'($urandom_range(2, 20));
         endcase
         cyc(e, ld, d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
